// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider and tick generator.
// Each channel's divisor and high time are double-buffered and reloaded only when its period wraps.
module clk_div_multi #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int RST_DIV  = 1,
    parameter int RST_HIGH = 1
) (
    input  logic                      clk_in,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       en,
    input  logic                      sync,
    input  logic [CHANNELS*CNT_W-1:0] div_in,
    input  logic [CHANNELS*CNT_W-1:0] high_in,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       running
);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_RST   = CNT_W'(RST_DIV);
    localparam logic [CNT_W-1:0] HIGH_RST  = CNT_W'(RST_HIGH);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div_act;
        logic [CNT_W-1:0] high_act;
        logic [CNT_W-1:0] div_nxt;
        logic [CNT_W-1:0] high_nxt;
        logic [CNT_W-1:0] cnt_inc;
        logic             wrap;
        logic             clk_r;
        logic             tick_r;
        logic             run_r;

        always_comb begin
            div_nxt  = div_in[g*CNT_W +: CNT_W];
            high_nxt = high_in[g*CNT_W +: CNT_W];
            cnt_inc  = cnt + ONE;
            // A not-yet-running channel wraps immediately, so enabling always begins a full period.
            wrap     = sync | ~run_r | (cnt == div_act);
        end

        always_ff @(posedge clk_in) begin
            if (rst) begin
                cnt      <= '0;
                div_act  <= DIV_RST;
                high_act <= HIGH_RST;
                clk_r    <= 1'b0;
                tick_r   <= 1'b0;
                run_r    <= 1'b0;
            end else if (!en[g]) begin
                cnt    <= '0;
                clk_r  <= 1'b0;
                tick_r <= 1'b0;
                run_r  <= 1'b0;
            end else if (wrap) begin
                cnt      <= '0;
                div_act  <= div_nxt;
                high_act <= high_nxt;
                clk_r    <= (high_nxt != '0);
                tick_r   <= 1'b1;
                run_r    <= 1'b1;
            end else begin
                cnt    <= cnt_inc;
                clk_r  <= (cnt_inc < high_act);
                tick_r <= 1'b0;
            end
        end

        assign clk_out[g] = clk_r;
        assign tick[g]    = tick_r;
        assign running[g] = run_r;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: each stimulus cycle queues hand-computed outputs,
// and a monitor pops and compares them just after the following clock edge.
module tb_clk_div_multi;

    localparam int CH = 4;
    localparam int W  = 16;

    logic            clk_in = 1'b0;
    logic            rst;
    logic            sync;
    logic [CH-1:0]   en;
    logic [CH*W-1:0] div_in;
    logic [CH*W-1:0] high_in;
    logic [CH-1:0]   clk_out;
    logic [CH-1:0]   tick;
    logic [CH-1:0]   running;

    typedef struct {
        logic [3:0]  c;
        logic [3:0]  t;
        logic [3:0]  r;
        int unsigned id;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned step_id  = 0;

    always #10 clk_in = ~clk_in;

    clk_div_multi #(
        .CHANNELS(CH),
        .CNT_W(W),
        .RST_DIV(1),
        .RST_HIGH(1)
    ) dut (
        .clk_in(clk_in),
        .rst(rst),
        .en(en),
        .sync(sync),
        .div_in(div_in),
        .high_in(high_in),
        .clk_out(clk_out),
        .tick(tick),
        .running(running)
    );

    task automatic set_ch(input int unsigned ch, input logic [W-1:0] d, input logic [W-1:0] h);
        div_in[ch*W +: W]  = d;
        high_in[ch*W +: W] = h;
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next posedge.
    task automatic step(input logic [3:0] e, input logic s, input logic r,
                        input logic [3:0] ec, input logic [3:0] et, input logic [3:0] er);
        exp_t x;
        en   = e;
        sync = s;
        rst  = r;
        x.c  = ec;
        x.t  = et;
        x.r  = er;
        x.id = step_id;
        step_id++;
        sb.push_back(x);
        @(negedge clk_in);
    endtask

    task automatic check(input string name, input int unsigned id,
                         input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %b expected %b", name, id, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk_in);
            #1;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                check("clk_out", x.id, clk_out, x.c);
                check("tick", x.id, tick, x.t);
                check("running", x.id, running, x.r);
            end
        end
    end

    initial begin : stimulus
        rst     = 1'b1;
        sync    = 1'b0;
        en      = '0;
        div_in  = '0;
        high_in = '0;
        @(negedge clk_in);

        // Reset state
        step(4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
        step(4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0);

        // ch0 div=3 high=2: 1,1,0,0 with tick on the first high
        set_ch(0, 16'd3, 16'd2);
        for (int p = 0; p < 2; p++) begin
            step(4'h1, 1'b0, 1'b0, 4'h1, 4'h1, 4'h1);
            step(4'h1, 1'b0, 1'b0, 4'h1, 4'h0, 4'h1);
            step(4'h1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h1);
            step(4'h1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h1);
        end

        // Reprogram at cnt=1: current period finishes unchanged, then div=5 high=1
        step(4'h1, 1'b0, 1'b0, 4'h1, 4'h1, 4'h1);
        step(4'h1, 1'b0, 1'b0, 4'h1, 4'h0, 4'h1);
        set_ch(0, 16'd5, 16'd1);
        step(4'h1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h1);
        step(4'h1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h1);
        step(4'h1, 1'b0, 1'b0, 4'h1, 4'h1, 4'h1);
        repeat (5) step(4'h1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h1);
        step(4'h1, 1'b0, 1'b0, 4'h1, 4'h1, 4'h1);

        // sync mid-period aligns ch0 (div=4) and ch1 (div=6); sync on a natural wrap ticks once
        step(4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        set_ch(0, 16'd4, 16'd2);
        set_ch(1, 16'd6, 16'd3);
        step(4'h3, 1'b0, 1'b0, 4'h3, 4'h3, 4'h3);
        step(4'h3, 1'b0, 1'b0, 4'h3, 4'h0, 4'h3);
        step(4'h3, 1'b0, 1'b0, 4'h2, 4'h0, 4'h3);
        step(4'h3, 1'b1, 1'b0, 4'h3, 4'h3, 4'h3);
        step(4'h3, 1'b0, 1'b0, 4'h3, 4'h0, 4'h3);
        step(4'h3, 1'b0, 1'b0, 4'h2, 4'h0, 4'h3);
        step(4'h3, 1'b0, 1'b0, 4'h0, 4'h0, 4'h3);
        step(4'h3, 1'b0, 1'b0, 4'h0, 4'h0, 4'h3);
        step(4'h3, 1'b1, 1'b0, 4'h3, 4'h3, 4'h3);
        step(4'h3, 1'b0, 1'b0, 4'h3, 4'h0, 4'h3);

        // Edge settings: ch1 high=0, ch2 high>div, ch3 div=0
        step(4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        set_ch(1, 16'd3, 16'd0);
        set_ch(2, 16'd3, 16'd9);
        set_ch(3, 16'd0, 16'd1);
        for (int p = 0; p < 2; p++) begin
            step(4'he, 1'b0, 1'b0, 4'hc, 4'he, 4'he);
            repeat (3) step(4'he, 1'b0, 1'b0, 4'hc, 4'h8, 4'he);
        end

        // Mid-high disable on ch2, then re-enable with new settings
        step(4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        set_ch(2, 16'd3, 16'd3);
        step(4'h4, 1'b0, 1'b0, 4'h4, 4'h4, 4'h4);
        step(4'h4, 1'b0, 1'b0, 4'h4, 4'h0, 4'h4);
        step(4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        set_ch(2, 16'd2, 16'd1);
        step(4'h4, 1'b0, 1'b0, 4'h4, 4'h4, 4'h4);
        step(4'h4, 1'b0, 1'b0, 4'h0, 4'h0, 4'h4);
        step(4'h4, 1'b0, 1'b0, 4'h0, 4'h0, 4'h4);
        step(4'h4, 1'b0, 1'b0, 4'h4, 4'h4, 4'h4);

        // Reset mid-operation with en held, including rst together with sync
        step(4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        for (int unsigned c = 0; c < CH; c++) set_ch(c, 16'd3, 16'd2);
        step(4'hf, 1'b0, 1'b0, 4'hf, 4'hf, 4'hf);
        step(4'hf, 1'b0, 1'b0, 4'hf, 4'h0, 4'hf);
        step(4'hf, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
        step(4'hf, 1'b0, 1'b0, 4'hf, 4'hf, 4'hf);
        step(4'hf, 1'b0, 1'b0, 4'hf, 4'h0, 4'hf);
        step(4'hf, 1'b0, 1'b0, 4'h0, 4'h0, 4'hf);
        step(4'hf, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
        step(4'hf, 1'b0, 1'b0, 4'hf, 4'hf, 4'hf);

        en = '0;
        repeat (4) @(negedge clk_in);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
